key_event_queue: RTL

- Consumer end of the debouncer interface. Takes the per-key one-cycle `just_pressed` / `just_released` pulse vectors and turns them into a serialised stream of key events.
- Each event is {press/release flag, key index}. Events are buffered in a small FIFO.
- The game FSM pops one event at a time over a valid/ready handshake, so it never scans 32-bit vectors itself.
- Sits directly between the debouncer and the game logic, in the same clock domain.

---
 rtl/key_event_pkg.sv | 11 +
 rtl/key_event_fifo.sv | 51 +++++
 rtl/key_event_queue.sv | 105 ++++++++++
 3 files changed

// File: rtl/key_event_pkg.sv
// Shared definitions for the key event queue: key count, index width and the
// queued event record.
package key_event_pkg;
  localparam int NUM_KEYS  = 32;
  localparam int KEY_IDX_W = $clog2(NUM_KEYS);

  typedef struct packed {
    logic                 press;
    logic [KEY_IDX_W-1:0] key;
  } key_event_t;
endpackage

// File: rtl/key_event_fifo.sv
// Synchronous circular FIFO of key_event_t; DEPTH must be a power of two so the
// pointers wrap by natural overflow.
module key_event_fifo
  import key_event_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  key_event_t       i_data,
  input  logic             i_pop,
  output key_event_t       o_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);
  key_event_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  // A push while full is only legal when a pop frees the head slot this cycle.
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end
endmodule

// File: rtl/key_event_queue.sv
// Serialises debouncer press/release pulse vectors into a FIFO of key events.
// Release events are only built when KEY_EVENT_RELEASE_EN is defined.
module key_event_queue
  import key_event_pkg::*;
#(
  parameter int INPUTS     = 32,
  parameter int FIFO_DEPTH = 8,
  localparam int IDX_W     = $clog2(INPUTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [INPUTS-1:0]           just_pressed,
  input  logic [INPUTS-1:0]           just_released,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic                        evt_press,
  output logic [IDX_W-1:0]            evt_key,
  output logic [$clog2(FIFO_DEPTH):0] evt_count,
  output logic                        overflow,
  input  logic                        overflow_clr
);
  logic [INPUTS-1:0] r_pend_press;
  logic [INPUTS-1:0] w_pend_rel;
  logic [INPUTS-1:0] w_any;
  logic [INPUTS-1:0] w_sel;
  logic [INPUTS-1:0] w_clr_press;
  logic [INPUTS-1:0] w_clr_rel;
  logic [IDX_W-1:0]  w_idx;
  logic              w_cand;
  logic              w_is_press;
  logic              w_pop;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic              w_ovf_set;
  key_event_t        w_in_evt;
  key_event_t        w_head;

  assign w_any  = r_pend_press | w_pend_rel;
  assign w_cand = |w_any;

  // Scan downward so the lowest pending index is the final assignment.
  always_comb begin
    w_idx = '0;
    for (int unsigned i = INPUTS; i > 0; i--) begin
      if (w_any[i-1]) w_idx = IDX_W'(i - 1);
    end
  end

  assign w_is_press  = r_pend_press[w_idx];
  assign w_pop       = evt_valid & evt_ready;
  assign w_push      = w_cand & (~w_full | w_pop);
  assign w_sel       = w_push ? (INPUTS'(1) << w_idx) : '0;
  assign w_clr_press = w_is_press ? w_sel : '0;
  assign w_clr_rel   = w_is_press ? '0 : w_sel;

  assign w_in_evt.press = w_is_press;
  assign w_in_evt.key   = KEY_IDX_W'(w_idx);

`ifdef KEY_EVENT_RELEASE_EN
  logic [INPUTS-1:0] r_pend_rel;
  assign w_pend_rel = r_pend_rel;
  assign w_ovf_set  = |(just_pressed & r_pend_press & ~w_clr_press)
                    | |(just_released & r_pend_rel & ~w_clr_rel);

  always_ff @(posedge clk) begin
    if (rst) r_pend_rel <= '0;
    else     r_pend_rel <= (r_pend_rel & ~w_clr_rel) | just_released;
  end

  assign evt_press = evt_valid & w_head.press;
`else
  logic w_unused_rel;
  assign w_unused_rel = ^{just_released, w_clr_rel, w_head.press};
  assign w_pend_rel   = '0;
  assign w_ovf_set    = |(just_pressed & r_pend_press & ~w_clr_press);
  assign evt_press    = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_press <= '0;
      overflow     <= 1'b0;
    end else begin
      r_pend_press <= (r_pend_press & ~w_clr_press) | just_pressed;
      if (w_ovf_set)         overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  key_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_in_evt),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (evt_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign evt_valid = ~w_empty;
  assign evt_key   = evt_valid ? IDX_W'(w_head.key) : '0;
endmodule
